// File: rtl/weight_update_scheduler_pkg.sv
// Shared constants and state encoding for the STDP weight-update scheduler.
// Default geometry and the count-mux/LUT latency live here so every block agrees.
package weight_update_scheduler_pkg;

    localparam int WUS_M      = 784;
    localparam int WUS_N      = 16;
    localparam int WUS_ADDR_W = 10;
    localparam int WUS_NSEL_W = 4;
    localparam int WUS_LAT    = 2;

    typedef enum logic [1:0] {
        WUS_IDLE  = 2'd0,
        WUS_SWEEP = 2'd1,
        WUS_DRAIN = 2'd2
    } wus_state_t;

endpackage

// File: rtl/weight_update_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first set request at or after ptr wins,
// wrapping modulo N. The pointer register is owned by the parent.
module weight_update_scheduler_rr_arbiter
    import weight_update_scheduler_pkg::*;
#(
    parameter int N      = WUS_N,
    parameter int NSEL_W = WUS_NSEL_W
) (
    input  logic [N-1:0]      req,
    input  logic [NSEL_W-1:0] ptr,
    output logic [N-1:0]      grant,
    output logic [NSEL_W-1:0] idx,
    output logic              any
);

    logic [NSEL_W-1:0] k;

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            k = NSEL_W'((int'(ptr) + i) % N);
            if (!any && req[k]) begin
                any      = 1'b1;
                grant[k] = 1'b1;
                idx      = k;
            end
        end
    end

endmodule

// File: rtl/weight_update_scheduler.sv
// Round-robin STDP sweep scheduler: grants one neuron at a time, sweeps inputs 0..M-1
// and emits write-back strobes delayed by LAT. Optional counters under WUS_PERF_CNT_EN.
module weight_update_scheduler
    import weight_update_scheduler_pkg::*;
#(
    parameter int M      = WUS_M,
    parameter int N      = WUS_N,
    parameter int ADDR_W = WUS_ADDR_W,
    parameter int NSEL_W = WUS_NSEL_W,
    parameter int LAT    = WUS_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req,
    input  logic              enable,
    input  logic              stall,
    output logic [ADDR_W-1:0] ip_select,
    output logic              rd_en,
    output logic [NSEL_W-1:0] neuron_sel,
    output logic              wb_en,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [NSEL_W-1:0] wb_neuron,
    output logic              busy,
    output logic              done,
    output logic [N-1:0]      pending
`ifdef WUS_PERF_CNT_EN
    ,
    output logic [15:0]       coalesce_cnt,
    output logic [31:0]       busy_cycles
`endif
);

    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(M - 1);
    localparam logic [2:0]        DRAIN_LAST = 3'(LAT - 1);

    wus_state_t        state, state_next;
    logic [NSEL_W-1:0] ptr;
    logic [N-1:0]      grant;
    logic [NSEL_W-1:0] winner;
    logic              any;
    logic              grant_fire;
    logic [2:0]        drain_cnt;

    logic [LAT-1:0]    dl_v;
    logic [ADDR_W-1:0] dl_a [LAT];
    logic [NSEL_W-1:0] dl_n [LAT];

    weight_update_scheduler_rr_arbiter #(.N(N), .NSEL_W(NSEL_W)) u_arb (
        .req   (pending),
        .ptr   (ptr),
        .grant (grant),
        .idx   (winner),
        .any   (any)
    );

    always_comb begin
        state_next = state;
        grant_fire = 1'b0;
        rd_en      = 1'b0;
        done       = 1'b0;
        case (state)
            WUS_IDLE: begin
                if (enable && any) begin
                    grant_fire = 1'b1;
                    state_next = WUS_SWEEP;
                end
            end
            WUS_SWEEP: begin
                rd_en = !stall;
                if (!stall && ip_select == LAST_ADDR) state_next = WUS_DRAIN;
            end
            WUS_DRAIN: begin
                // The final delayed strobe leaves the line on the last non-stalled drain cycle.
                if (!stall && drain_cnt == DRAIN_LAST) begin
                    done       = 1'b1;
                    state_next = WUS_IDLE;
                end
            end
            default: state_next = WUS_IDLE;
        endcase
    end

    assign busy = (state != WUS_IDLE);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= WUS_IDLE;
            ptr        <= '0;
            pending    <= '0;
            neuron_sel <= '0;
            ip_select  <= '0;
            drain_cnt  <= '0;
        end else begin
            state   <= state_next;
            // A same-cycle request for the granted neuron re-arms it: set wins over clear.
            pending <= (pending & ~(grant_fire ? grant : '0)) | req;
            if (grant_fire) begin
                neuron_sel <= winner;
                ip_select  <= '0;
                ptr        <= (winner == NSEL_W'(N - 1)) ? '0 : winner + 1'b1;
            end else if (rd_en && ip_select != LAST_ADDR) begin
                ip_select <= ip_select + 1'b1;
            end
            if (state == WUS_DRAIN) begin
                if (!stall) drain_cnt <= drain_cnt + 1'b1;
            end else begin
                drain_cnt <= '0;
            end
        end
    end

    // NOTE: the delay line is small and reset so an abort can never leak a stale strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dl_v <= '0;
            for (int i = 0; i < LAT; i++) begin
                dl_a[i] <= '0;
                dl_n[i] <= '0;
            end
        end else if (!stall) begin
            dl_v[0] <= rd_en;
            dl_a[0] <= ip_select;
            dl_n[0] <= neuron_sel;
            for (int i = 1; i < LAT; i++) begin
                dl_v[i] <= dl_v[i-1];
                dl_a[i] <= dl_a[i-1];
                dl_n[i] <= dl_n[i-1];
            end
        end
    end

    assign wb_en     = dl_v[LAT-1] & ~stall;
    assign wb_addr   = dl_a[LAT-1];
    assign wb_neuron = dl_n[LAT-1];

`ifdef WUS_PERF_CNT_EN
    logic [16:0] coalesce_sum;

    assign coalesce_sum = {1'b0, coalesce_cnt} + 17'($countones(req & pending));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coalesce_cnt <= '0;
            busy_cycles  <= '0;
        end else begin
            coalesce_cnt <= coalesce_sum[16] ? 16'hFFFF : coalesce_sum[15:0];
            busy_cycles  <= busy_cycles + 32'(busy);
        end
    end
`endif

endmodule

// File: doc/weight_update_scheduler.md
Name: weight_update_scheduler

Overview:
Sequences STDP weight-change sweeps for the SNN learning path.
- Collects per-neuron fire requests (start_wch) and arbitrates among them round-robin.
- For each granted neuron, sweeps the input index 0..M-1 into the count mux / LUT pipeline.
- Issues aligned write-back strobes to the weight memory.
- Sits between the neuron array and the count-mux / delta-LUT / weight-RAM datapath, replacing free-running index counters.

Parameters:
- M, 784, synapses (inputs) per neuron.
- N, 16, number of neurons / requesters.
- ADDR_W, 10, input-index width; must satisfy 2^ADDR_W >= M.
- NSEL_W, 4, neuron-select width; must satisfy 2^NSEL_W >= N.
- LAT, 2, cycles from ip_select issue to delta valid at the weight-RAM (mux register + LUT register); range 1..7.

Ports:
- clk  in  1  clock.
- rst  in  1  reset. Asynchronous, active-high.
- req  in  N  per-neuron weight-change request pulses (start_wch).
- enable  in  1  when low, no new grant is issued; an in-progress sweep completes.
- stall  in  1  freezes the sweep counter and the write-back delay line.
- ip_select  out  ADDR_W  input index driven to the count mux.
- rd_en  out  1  ip_select valid this cycle.
- neuron_sel  out  NSEL_W  neuron currently being updated.
- wb_en  out  1  write weight[wb_neuron][wb_addr] with the current delta.
- wb_addr  out  ADDR_W  ip_select delayed by LAT.
- wb_neuron  out  NSEL_W  neuron_sel delayed by LAT.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when a neuron's last write-back completes.
- pending  out  N  latched, not-yet-serviced requests.

Behaviour:
- Reset values: all outputs 0; pending = 0; round-robin pointer = 0; state = IDLE.
- Request latching:
  - pending |= req every cycle.
  - The granted bit is cleared in the grant cycle.
  - A req bit asserted in that same cycle for the granted neuron re-sets its pending bit (set wins), so it is serviced again later.
  - Repeated reqs for an already-pending neuron coalesce into one pending bit.
- Arbitration:
  - Round-robin: search starts at (last_grant+1) mod N, wrapping.
  - After reset, the search starts at neuron 0.
- States:
  - IDLE: if enable && |pending, grant the winner, neuron_sel <= winner, ip_select <= 0, go to SWEEP.
  - SWEEP:
    - rd_en = 1 while !stall; ip_select increments by 1 per non-stalled cycle.
    - On the cycle ip_select == M-1 is issued (not stalled), go to DRAIN.
    - ip_select never exceeds M-1.
  - DRAIN:
    - rd_en = 0; wait until the delay line is empty (LAT non-stalled cycles).
    - Assert done with the final wb_en, on the same cycle.
    - Then go to IDLE.
- Back-to-back sweeps: IDLE→SWEEP costs exactly one cycle. Minimum period per neuron is M + LAT + 1 cycles with no stall.
- Delay line:
  - LAT-stage shift of {rd_en, ip_select, neuron_sel}; its outputs are {wb_en, wb_addr, wb_neuron}.
  - Advances only when !stall.
  - wb_en is forced 0 while stall = 1.
- Stall in IDLE: has no effect on arbitration. Grants may still occur, and SWEEP then holds at index 0.
- enable deassertion mid-sweep: ignored until return to IDLE.
- rst mid-sweep: immediate abort. No further wb_en; pending is lost.
- Exactly M wb_en pulses occur per grant, addresses 0..M-1 in order, with no gaps other than stalls.

Optional Feature:
- Macro: WUS_PERF_CNT_EN.
- Defined:
  - Adds output coalesce_cnt [15:0]: counts req bits arriving while their pending bit is already 1. Saturates at 16'hFFFF.
  - Adds output busy_cycles [31:0]: counts cycles with busy = 1. Wraps.
  - Both reset to 0.
- Undefined: neither port nor its logic exists; all other behaviour is identical.

Decomposition:
- Shared header (header.vh):
  - M/N defaults and ADDR_W/NSEL_W.
  - State encodings WUS_IDLE = 2'd0, WUS_SWEEP = 2'd1, WUS_DRAIN = 2'd2.
  - LAT default, so the count mux and LUT latency constant are defined in one place.
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant, encoded index, any.
  - Combinational; the pointer register lives in the parent.

Test Plan:
1. Reset, then a req[5] pulse → next cycle busy = 1, neuron_sel = 5. wb_en pulses 784 times with wb_addr 0..783, the first at LAT = 2 cycles after the first rd_en. done fires with wb_addr = 783; total M+LAT+1 = 787 cycles from grant to IDLE.
2. req[3] and req[9] in the same cycle → neuron 3 swept first, then 9. pending shows 0x0208 → 0x0200 → 0x0000.
3. Round-robin: with last_grant = 9, pending = {2,9,12} → order 12, 2, 9.
4. stall held 10 cycles at ip_select = 100 → ip_select stays 100 and wb_en = 0 during the stall. After release the wb_addr sequence resumes with no gap or duplicate; total wb_en count remains 784.
5. req[5] re-pulsed mid-sweep of neuron 5, plus two more pulses → pending[5] = 1 and neuron 5 is swept exactly once more. With WUS_PERF_CNT_EN, coalesce_cnt = 2.
6. rst asserted at ip_select = 400 → all outputs 0 and pending = 0 within the same cycle (asynchronous). No wb_en after release; a new req[0] sweeps from index 0.
